// File: rtl/pipelined_cache_control_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_cache_control_pkg
//   Shared types and constants for the 2-way, 8-set, 256-bit-line pipelined
//   cache controller.
//   Contents:
//     cache_ctrl_state_t  - sequencing FSM states
//     NUM_WAYS, LINE_W    - cache geometry
//     ADDR_SEL_*          - encodings for the pmem address mux select
//     way_onehot()        - way index to per-way enable vector
// -----------------------------------------------------------------------------
package pipelined_cache_control_pkg;

    localparam int NUM_WAYS = 2;
    localparam int LINE_W   = 256;

    // pmem address mux: the request line address or the victim {tag,set}.
    localparam logic ADDR_SEL_REQ    = 1'b0;
    localparam logic ADDR_SEL_VICTIM = 1'b1;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } cache_ctrl_state_t;

    function automatic logic [NUM_WAYS-1:0] way_onehot(input logic way);
        return way ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// -----------------------------------------------------------------------------
// cache_perf_counters
//   Hit and miss performance counters for the cache controller. Both wrap
//   modulo 2^CNT_W. A hit that replays a request after a refill is not a new
//   hit, so it is suppressed via replay_i.
//   Ports:
//     clk, rst       - clock, synchronous active-high reset (clears counters)
//     hit_evt_i      - a request hit in the compare cycle this clock
//     miss_evt_i     - a request missed in the compare cycle this clock
//     replay_i       - the current hit is the replay of a refilled miss
//     hit_count_o    - hits serviced
//     miss_count_o   - misses detected
// -----------------------------------------------------------------------------
module cache_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit_evt_i,
    input  logic             miss_evt_i,
    input  logic             replay_i,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    logic [CNT_W-1:0] hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_evt_i && !replay_i) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if (miss_evt_i) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: rtl/pipelined_cache_control.sv
// -----------------------------------------------------------------------------
// pipelined_cache_control
//   Sequencing FSM for the 2-way, 8-set, 256-bit-line pipelined cache. It
//   watches the stage-2 outputs of the pipeline register stage and drives the
//   register-stage load/stall, the array write enables and the pmem handshake.
//   Hits respond in the compare cycle; misses stall through writeback,
//   allocate and refill, after which the held request is replayed as a hit.
//   Ports:
//     clk, rst            - clock, synchronous active-high reset
//     req_valid_i/_write_i- stage-2 request present / is a write
//     hit_i, hit_way_i    - registered hit and the way that hit
//     dirty_i, lru_i      - victim dirty bit and victim way
//     pmem_resp_i         - pmem line transfer done (one-cycle pulse)
//     pmem_read_o/_write_o, pmem_addr_sel_o - pmem request and address select
//     pipe_load_o, stall_o- register-stage load enable / hold
//     mem_resp_o          - CPU response
//     data_sel_o, data_load_o, tag_load_o, valid_load_o,
//     dirty_load_o, dirty_val_o, lru_load_o, lru_val_o - array writes
//     hit_count_o, miss_count_o - performance counters
// -----------------------------------------------------------------------------
module pipelined_cache_control
    import pipelined_cache_control_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    input  logic             req_write_i,
    input  logic             hit_i,
    input  logic             hit_way_i,
    input  logic             dirty_i,
    input  logic             lru_i,
    input  logic             pmem_resp_i,
    output logic             pmem_read_o,
    output logic             pmem_write_o,
    output logic             pmem_addr_sel_o,
    output logic             pipe_load_o,
    output logic             stall_o,
    output logic             mem_resp_o,
    output logic             data_sel_o,
    output logic [1:0]       data_load_o,
    output logic [1:0]       tag_load_o,
    output logic [1:0]       valid_load_o,
    output logic [1:0]       dirty_load_o,
    output logic             dirty_val_o,
    output logic             lru_load_o,
    output logic             lru_val_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic [CNT_W-1:0] miss_count_o
);

    // The controller only needs the set index width to be sane; the arrays
    // themselves live in the datapath.
    if (S_INDEX < 1) begin : g_bad_geometry
        $error("pipelined_cache_control: S_INDEX must be at least 1");
    end

    cache_ctrl_state_t state_q, state_d;
    logic              replay_q, replay_d;
    logic              hit_evt, miss_evt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_COMPARE;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        replay_d = replay_q;
        case (state_q)
            ST_COMPARE: begin
                if (req_valid_i && hit_i) begin
                    replay_d = 1'b0;
                end else if (req_valid_i) begin
                    state_d = dirty_i ? ST_WRITEBACK : ST_ALLOCATE;
                end
            end
            ST_WRITEBACK: begin
                if (pmem_resp_i) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                if (pmem_resp_i) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                // The register stage recaptures this cycle, so the next
                // compare is the replay of the held request.
                replay_d = 1'b1;
                state_d  = ST_COMPARE;
            end
            default: state_d = ST_COMPARE;
        endcase
    end

    // Output logic
    always_comb begin
        pmem_read_o     = 1'b0;
        pmem_write_o    = 1'b0;
        pmem_addr_sel_o = ADDR_SEL_REQ;
        pipe_load_o     = 1'b0;
        stall_o         = 1'b0;
        mem_resp_o      = 1'b0;
        data_sel_o      = 1'b0;
        data_load_o     = 2'b00;
        tag_load_o      = 2'b00;
        valid_load_o    = 2'b00;
        dirty_load_o    = 2'b00;
        dirty_val_o     = 1'b0;
        lru_load_o      = 1'b0;
        lru_val_o       = 1'b0;
        hit_evt         = 1'b0;
        miss_evt        = 1'b0;
        case (state_q)
            ST_COMPARE: begin
                if (!req_valid_i) begin
                    pipe_load_o = 1'b1;
                end else if (hit_i) begin
                    mem_resp_o  = 1'b1;
                    pipe_load_o = 1'b1;
                    lru_load_o  = 1'b1;
                    lru_val_o   = ~hit_way_i;
                    hit_evt     = 1'b1;
                    if (req_write_i) begin
                        // Byte-masked CPU data merges into the hitting way.
                        data_load_o  = way_onehot(hit_way_i);
                        dirty_load_o = way_onehot(hit_way_i);
                        dirty_val_o  = 1'b1;
                    end
                end else begin
                    stall_o  = 1'b1;
                    miss_evt = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                pmem_write_o    = 1'b1;
                pmem_addr_sel_o = ADDR_SEL_VICTIM;
                stall_o         = 1'b1;
            end
            ST_ALLOCATE: begin
                pmem_read_o     = 1'b1;
                pmem_addr_sel_o = ADDR_SEL_REQ;
                stall_o         = 1'b1;
                if (pmem_resp_i) begin
                    // Fill the victim way with the clean line from pmem.
                    data_sel_o   = 1'b1;
                    data_load_o  = way_onehot(lru_i);
                    tag_load_o   = way_onehot(lru_i);
                    valid_load_o = way_onehot(lru_i);
                    dirty_load_o = way_onehot(lru_i);
                    dirty_val_o  = 1'b0;
                end
            end
            ST_REFILL: begin
                pipe_load_o = 1'b1;
                stall_o     = 1'b1;
            end
            default: ;
        endcase
    end

    cache_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk          (clk),
        .rst          (rst),
        .hit_evt_i    (hit_evt),
        .miss_evt_i   (miss_evt),
        .replay_i     (replay_q),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );

endmodule

// File: tb/tb_pipelined_cache_control.sv
// -----------------------------------------------------------------------------
// tb_pipelined_cache_control
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a transaction-level model of the miss-handling sequence.
// -----------------------------------------------------------------------------
module tb_pipelined_cache_control;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, req_valid, req_write, hit, hit_way, dirty, lru, pmem_resp;
    logic pmem_read, pmem_write, pmem_addr_sel, pipe_load, stall, mem_resp;
    logic data_sel, dirty_val, lru_load, lru_val;
    logic [1:0] data_load, tag_load, valid_load, dirty_load;
    logic [CNT_W-1:0] hit_count, miss_count;

    pipelined_cache_control #(.S_INDEX(3), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_write_i     (req_write),
        .hit_i           (hit),
        .hit_way_i       (hit_way),
        .dirty_i         (dirty),
        .lru_i           (lru),
        .pmem_resp_i     (pmem_resp),
        .pmem_read_o     (pmem_read),
        .pmem_write_o    (pmem_write),
        .pmem_addr_sel_o (pmem_addr_sel),
        .pipe_load_o     (pipe_load),
        .stall_o         (stall),
        .mem_resp_o      (mem_resp),
        .data_sel_o      (data_sel),
        .data_load_o     (data_load),
        .tag_load_o      (tag_load),
        .valid_load_o    (valid_load),
        .dirty_load_o    (dirty_load),
        .dirty_val_o     (dirty_val),
        .lru_load_o      (lru_load),
        .lru_val_o       (lru_val),
        .hit_count_o     (hit_count),
        .miss_count_o    (miss_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: a miss in progress is a list of outstanding jobs -- an optional
    // writeback, a fill, and one recapture cycle -- after which the next
    // compare is a free (uncounted) replay hit.
    bit m_miss;            // miss being serviced
    bit m_wb_todo;         // victim still to be written back
    bit m_fill_todo;       // line still to be fetched
    bit m_recapture;       // fill done, register stage recapturing
    bit m_replay;          // next compare hit is the replay
    logic [CNT_W-1:0] m_hits, m_misses;

    task automatic model_reset();
        m_miss = 0; m_wb_todo = 0; m_fill_todo = 0; m_recapture = 0; m_replay = 0;
        m_hits = '0; m_misses = '0;
    endtask

    function automatic logic [1:0] way_bit(input logic w);
        logic [1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Expected outputs for the current inputs, then compare.
    task automatic check_outputs();
        logic e_rd, e_wr, e_sel, e_pl, e_st, e_resp, e_dsel, e_dval, e_lld, e_lval;
        logic [1:0] e_dl, e_tl, e_vl, e_dyl;
        {e_rd, e_wr, e_sel, e_pl, e_st, e_resp, e_dsel, e_dval, e_lld, e_lval} = '0;
        {e_dl, e_tl, e_vl, e_dyl} = '0;
        if (!m_miss) begin
            if (!req_valid) e_pl = 1;
            else if (hit) begin
                e_resp = 1; e_pl = 1; e_lld = 1; e_lval = !hit_way;
                if (req_write) begin
                    e_dl = way_bit(hit_way); e_dyl = way_bit(hit_way); e_dval = 1;
                end
            end else e_st = 1;
        end else if (m_wb_todo) begin
            e_wr = 1; e_sel = 1; e_st = 1;
        end else if (m_fill_todo) begin
            e_rd = 1; e_st = 1;
            if (pmem_resp) begin
                e_dsel = 1; e_dl = way_bit(lru); e_tl = way_bit(lru);
                e_vl = way_bit(lru); e_dyl = way_bit(lru);
            end
        end else begin
            e_pl = 1; e_st = 1;
        end
        chk("pmem_read", pmem_read, e_rd);
        chk("pmem_write", pmem_write, e_wr);
        chk("addr_sel", pmem_addr_sel, e_sel);
        chk("pipe_load", pipe_load, e_pl);
        chk("stall", stall, e_st);
        chk("mem_resp", mem_resp, e_resp);
        chk("data_sel", data_sel, e_dsel);
        chk("data_load", data_load, e_dl);
        chk("tag_load", tag_load, e_tl);
        chk("valid_load", valid_load, e_vl);
        chk("dirty_load", dirty_load, e_dyl);
        chk("dirty_val", dirty_val, e_dval);
        chk("lru_load", lru_load, e_lld);
        chk("lru_val", lru_val, e_lval);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (!m_miss) begin
            if (req_valid && hit) begin
                if (!m_replay) m_hits = m_hits + 1'b1;
                m_replay = 0;
            end else if (req_valid) begin
                m_misses = m_misses + 1'b1;
                m_miss = 1; m_wb_todo = dirty; m_fill_todo = 1;
            end
        end else if (m_wb_todo) begin
            if (pmem_resp) m_wb_todo = 0;
        end else if (m_fill_todo) begin
            if (pmem_resp) begin m_fill_todo = 0; m_recapture = 1; end
        end else begin
            m_recapture = 0; m_miss = 0; m_replay = 1;
        end
    endtask

    // One clock: drive inputs, check mid-cycle, advance model at the edge.
    task automatic cyc(input logic r, input logic v, input logic w, input logic h,
                       input logic hw, input logic d, input logic l, input logic p);
        rst = r; req_valid = v; req_write = w; hit = h;
        hit_way = hw; dirty = d; lru = l; pmem_resp = p;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic held_write, held_lru;

    initial begin
        model_reset();
        rst = 1; {req_valid, req_write, hit, hit_way, dirty, lru, pmem_resp} = '0;
        @(posedge clk); #1;
        model_step();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Idle after reset
        repeat (5) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Read hit way 1, write hit way 0
        cyc(0, 1, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0);
        // Clean read miss, victim way 1, fill response after 4 cycles
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 1, 1, 0, 1, 0);
        // Dirty write miss: writeback, then fill, then replay
        cyc(0, 1, 1, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 1, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0, 1);
        repeat (2) cyc(0, 1, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 1, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("dir_hits", hit_count, 64'd2);
        chk("dir_misses", miss_count, 64'd2);
        @(posedge clk); #1;
        // Reset during writeback, stray pmem response the cycle after
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_hits", hit_count, 64'd0);
        chk("rst_misses", miss_count, 64'd0);
        @(posedge clk); #1;

        // Randomized traffic
        held_write = 0; held_lru = 0;
        for (int i = 0; i < 4000; i++) begin
            logic r, v, w, h, hw, d, l, p;
            r  = ($urandom_range(0, 299) == 0);
            hw = 1'($urandom);
            d  = 1'($urandom);
            if (!m_miss && m_replay) begin
                v = 1; w = held_write; h = 1; l = held_lru;
                p = ($urandom_range(0, 9) == 0);
            end else if (!m_miss) begin
                v = ($urandom_range(0, 3) != 0);
                w = 1'($urandom);
                h = ($urandom_range(0, 9) < 6);
                l = 1'($urandom);
                p = ($urandom_range(0, 9) == 0);
                held_write = w; held_lru = l;
            end else begin
                v = 1; w = held_write; h = 1'($urandom); l = held_lru;
                p = (m_wb_todo || m_fill_todo) ? ($urandom_range(0, 9) < 3)
                                                : ($urandom_range(0, 9) == 0);
            end
            cyc(r, v, w, h, hw, d, l, p);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_cache_control.md
Name: pipelined_cache_control

Overview:
- Sequencing FSM for the 2-way, 8-set, 256-bit-line pipelined cache.
- Watches the stage-2 outputs of the pipeline register stage (hit, hit way, victim dirty, LRU).
- Drives the register-stage load/stall, the array write enables and the cacheline memory port (pmem) handshake.
- Hits respond in the compare cycle; misses stall the pipeline through writeback, allocate and refill, then replay the held request.

Parameters:
S_INDEX, 3, set index width (8 sets); used only for counter and array enable sizing consistency
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid_i  input  1  stage-2 holds a valid CPU request (registered read or write)
req_write_i  input  1  stage-2 request is a write
hit_i  input  1  registered hit from the pipeline register stage
hit_way_i  input  1  way that hit (0/1)
dirty_i  input  1  dirty bit of the LRU victim way
lru_i  input  1  victim way
pmem_resp_i  input  1  cacheline memory done (one-cycle pulse)
pmem_read_o  output  1  cacheline read request
pmem_write_o  output  1  cacheline write request
pmem_addr_sel_o  output  1  0 = request line address, 1 = victim {tag,set} address
pipe_load_o  output  1  load enable for the pipeline register stage
stall_o  output  1  hold stage-1 address/write data in the register stage
mem_resp_o  output  1  response to CPU
data_sel_o  output  1  array write data: 0 = CPU write data with byte mask, 1 = pmem line
data_load_o  output  2  per-way data array write enable
tag_load_o  output  2  per-way tag write enable
valid_load_o  output  2  per-way valid set
dirty_load_o  output  2  per-way dirty write enable
dirty_val_o  output  1  dirty value written
lru_load_o  output  1  LRU write enable
lru_val_o  output  1  new LRU (victim) way
hit_count_o  output  CNT_W  hits serviced
miss_count_o  output  CNT_W  misses detected

Behaviour:
- Outputs are combinational from state and inputs (Moore plus qualified Mealy). All enables default to 0.
- Reset state is COMPARE, with both counters and replay_q cleared.
  - Immediately after reset: pmem_read_o = pmem_write_o = 0, stall_o = 0, pipe_load_o = 1 (since req_valid_i = 0).
- States: COMPARE, WRITEBACK, ALLOCATE, REFILL.
- COMPARE, !req_valid_i: pipe_load_o = 1, stall_o = 0; stay in COMPARE.
- COMPARE, req_valid_i & hit_i:
  - mem_resp_o = 1, pipe_load_o = 1, lru_load_o = 1, lru_val_o = ~hit_way_i.
  - If req_write_i: data_load_o[hit_way_i] = 1, data_sel_o = 0, dirty_load_o[hit_way_i] = 1, dirty_val_o = 1.
  - hit_count increments unless replay_q; replay_q clears.
  - Stay in COMPARE. Single-cycle hit latency.
- COMPARE, req_valid_i & !hit_i:
  - pipe_load_o = 0, stall_o = 1, miss_count increments.
  - Next state is WRITEBACK if dirty_i, else ALLOCATE.
- WRITEBACK:
  - pmem_write_o = 1, pmem_addr_sel_o = 1, stall_o = 1, pipe_load_o = 0.
  - Hold until pmem_resp_i, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read_o = 1, pmem_addr_sel_o = 0, stall_o = 1, pipe_load_o = 0.
  - On pmem_resp_i, in the same cycle: data_load_o[lru_i] = 1, data_sel_o = 1, tag_load_o[lru_i] = 1, valid_load_o[lru_i] = 1, dirty_load_o[lru_i] = 1, dirty_val_o = 0.
  - Then go to REFILL.
- REFILL:
  - pipe_load_o = 1, stall_o = 1: the register stage recaptures hit/dirty/lru for the held address.
  - Set replay_q; go to COMPARE.
  - The next COMPARE cycle is a guaranteed hit and services the original request (write merges CPU data).
- pmem requests stay asserted and stable until pmem_resp_i; pmem_resp_i outside WRITEBACK/ALLOCATE is ignored.
- Exactly one miss is counted per miss, regardless of writeback. The replay hit is not counted.
- Counters wrap modulo 2^CNT_W.
- rst mid-operation (any state): the next state is COMPARE, pmem requests drop at that edge, and in-flight pmem_resp_i is ignored.

Decomposition:
- Shared package (rv32i_types or a cache package) holds:
  - state enum `cache_ctrl_state_t`;
  - localparams for way count (2), line width (256) and pmem address-select encodings.
- One natural sub-module: `cache_perf_counters`, holding the hit/miss counters with wrap and replay suppression.

Test Plan:
- Reset, then req_valid_i = 0 for 5 cycles -> pipe_load_o = 1, stall_o = 0, pmem_* = 0, counters = 0.
- Read hit: req_valid_i = 1, hit_i = 1, hit_way_i = 1 -> same-cycle mem_resp_o = 1, lru_load_o = 1, lru_val_o = 0, hit_count = 1.
- Write hit on way 0 -> data_load_o = 2'b01, dirty_load_o = 2'b01, dirty_val_o = 1, data_sel_o = 0.
- Clean read miss, lru_i = 1, pmem_resp_i after 4 cycles:
  - sequence is ALLOCATE, then fills way 1 (tag/valid/data_load_o = 2'b10, dirty_val_o = 0), then REFILL, then a COMPARE hit with mem_resp_o = 1;
  - miss_count = 1, hit_count unchanged.
- Dirty miss -> pmem_write_o with addr_sel = 1 until resp, then pmem_read_o with addr_sel = 0; stall_o = 1 throughout; exactly one mem_resp_o.
- rst asserted during WRITEBACK with a pmem_resp_i pulse the following cycle -> state COMPARE, pmem_write_o = 0, no array writes, counters = 0.
